// File: rtl/dec_4.sv
`default_nettype none
// ============================================================================
// Module   : dec_4
// Purpose  : Decoder-side dense layer, y = act(W*z + b), mapping a 2-element
//            latent vector to a 6-element reconstruction. Six signed
//            fixed-point MAC lanes run in parallel and step over the two
//            latent elements, saturating after every multiply and every add.
// Ports    : clk    - clock
//            reset  - asynchronous, active-high reset
//            start  - request, sampled only while idle
//            z      - latent vector, element k at z[BITSIZE*k +: BITSIZE]
//            w      - weights, input k -> output i at
//                     w[BITSIZE*6*k + BITSIZE*i +: BITSIZE]
//            b      - bias, element i at b[BITSIZE*i +: BITSIZE]
//            y      - registered result, element i at y[BITSIZE*i +: BITSIZE]
//            valid  - one-cycle pulse when y is updated
//            busy   - high while a computation is in flight
// Revision : 1.0 - initial release
// ============================================================================
module dec_4 #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int ACT     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BITSIZE*2-1:0]   z,
  input  logic [BITSIZE*12-1:0]  w,
  input  logic [BITSIZE*6-1:0]   b,
  output logic [BITSIZE*6-1:0]   y,
  output logic                   valid,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [BITSIZE-1:0] C_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [BITSIZE-1:0] C_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

  // Full-width signed product, floor shift by FRAC, then clamp. The shifted
  // value fits in BITSIZE bits only when its top BITSIZE+1 bits are all
  // copies of the sign.
  function automatic logic [BITSIZE-1:0] smul(input logic [BITSIZE-1:0] a,
                                              input logic [BITSIZE-1:0] c);
    logic [2*BITSIZE-1:0] p;
    logic [2*BITSIZE-1:0] s;
    p = {{BITSIZE{a[BITSIZE-1]}}, a} * {{BITSIZE{c[BITSIZE-1]}}, c};
    s = $signed(p) >>> FRAC;
    if ((&s[2*BITSIZE-1:BITSIZE-1]) || !(|s[2*BITSIZE-1:BITSIZE-1]))
      smul = s[BITSIZE-1:0];
    else
      smul = s[2*BITSIZE-1] ? C_MIN : C_MAX;
  endfunction

  // One-bit-wider sum; overflow shows up as disagreement of the top two bits.
  function automatic logic [BITSIZE-1:0] sadd(input logic [BITSIZE-1:0] a,
                                              input logic [BITSIZE-1:0] c);
    logic [BITSIZE:0] s;
    s = {a[BITSIZE-1], a} + {c[BITSIZE-1], c};
    if (s[BITSIZE] == s[BITSIZE-1])
      sadd = s[BITSIZE-1:0];
    else
      sadd = s[BITSIZE] ? C_MIN : C_MAX;
  endfunction

  logic [1:0]             state_q;
  logic                   k_q;
  logic [BITSIZE*2-1:0]   zr_q;
  logic [BITSIZE*12-1:0]  wr_q;
  logic [BITSIZE*6-1:0]   acc_q;
  logic [BITSIZE*6-1:0]   y_q;
  logic                   valid_q;

  logic [BITSIZE-1:0]     z_sel;
  logic [BITSIZE*6-1:0]   acc_d;
  logic [BITSIZE*6-1:0]   y_d;

  assign z_sel = k_q ? zr_q[BITSIZE +: BITSIZE] : zr_q[0 +: BITSIZE];

  generate
    for (genvar i = 0; i < 6; i++) begin : g_lane
      logic [BITSIZE-1:0] acc_cur;
      logic [BITSIZE-1:0] w_sel;
      assign acc_cur = acc_q[BITSIZE*i +: BITSIZE];
      assign w_sel   = k_q ? wr_q[BITSIZE*6 + BITSIZE*i +: BITSIZE]
                           : wr_q[BITSIZE*i +: BITSIZE];
      assign acc_d[BITSIZE*i +: BITSIZE] = sadd(acc_cur, smul(z_sel, w_sel));
      // ReLU clears negatives only; zero and positives pass unchanged.
      assign y_d[BITSIZE*i +: BITSIZE] =
        ((ACT == 1) && acc_cur[BITSIZE-1]) ? '0 : acc_cur;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 1'b0;
      zr_q    <= '0;
      wr_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            zr_q    <= z;
            wr_q    <= w;
            acc_q   <= b;
            k_q     <= 1'b0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          if (!k_q) begin
            k_q <= 1'b1;
          end else begin
            k_q     <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          y_q     <= y_d;
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dec_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_4
// Purpose  : Self-checking bench for dec_4. Two instances share stimulus, one
//            with identity activation and one with ReLU. Directed vectors
//            with hand-computed results, plus handshake and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_4;
  localparam int BS = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [BS*2-1:0]  z = '0;
  logic [BS*12-1:0] w = '0;
  logic [BS*6-1:0]  b = '0;
  logic [BS*6-1:0]  y0, y1;
  logic           v0, v1, bz0, bz1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_4 #(.BITSIZE(BS), .FRAC(8), .ACT(0)) u_id (
    .clk(clk), .reset(reset), .start(start), .z(z), .w(w), .b(b),
    .y(y0), .valid(v0), .busy(bz0));

  dec_4 #(.BITSIZE(BS), .FRAC(8), .ACT(1)) u_relu (
    .clk(clk), .reset(reset), .start(start), .z(z), .w(w), .b(b),
    .y(y1), .valid(v1), .busy(bz1));

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [95:0] rep6(input logic [15:0] x);
    return {6{x}};
  endfunction

  typedef struct {
    string        name;
    logic [31:0]  z;
    logic [191:0] w;
    logic [95:0]  b;
    logic [95:0]  e0;
    logic [95:0]  e1;
  } vec_t;

  vec_t vt[7];

  // Issue one start and wait for valid. lat is the index of the edge (start
  // edge = 0) after which valid was seen, or -1 on timeout.
  task automatic run_op(input logic [31:0] tz, input logic [191:0] tw,
                        input logic [95:0] tb, output int lat,
                        output int nbusy);
    @(negedge clk);
    z = tz; w = tw; b = tb; start = 1'b1;
    lat = -1; nbusy = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (n == 0) start = 1'b0;
      if (v0) begin
        lat = n;
        break;
      end
      if (bz0) nbusy++;
    end
  endtask

  initial begin
    int lat, nb, cnt, bad;
    logic [95:0] ycap;

    vt[0] = '{"basic", {16'h0200, 16'h0100}, {rep6(16'h0080), rep6(16'h0080)},
              rep6(16'h0000), rep6(16'h0180), rep6(16'h0180)};
    vt[1] = '{"lanes", {16'h0000, 16'h0100},
              {rep6(16'h1234), 16'h0500, 16'h0400, 16'h0300, 16'h0200,
               16'h0100, 16'h0000},
              rep6(16'h0010),
              {16'h0510, 16'h0410, 16'h0310, 16'h0210, 16'h0110, 16'h0010},
              {16'h0510, 16'h0410, 16'h0310, 16'h0210, 16'h0110, 16'h0010}};
    vt[2] = '{"sat_pos", {16'h7FFF, 16'h7FFF}, {rep6(16'h7FFF), rep6(16'h7FFF)},
              rep6(16'h7FFF), rep6(16'h7FFF), rep6(16'h7FFF)};
    vt[3] = '{"sat_neg", {16'h8000, 16'h8000}, {rep6(16'h7FFF), rep6(16'h7FFF)},
              rep6(16'h8000), rep6(16'h8000), rep6(16'h0000)};
    vt[4] = '{"act", {16'h0100, 16'h0100}, {rep6(16'hFF00), rep6(16'hFF00)},
              rep6(16'h0000), rep6(16'hFE00), rep6(16'h0000)};
    vt[5] = '{"floor", {16'h0000, 16'hFFFF}, {rep6(16'h0001), rep6(16'h0001)},
              rep6(16'h0000), rep6(16'hFFFF), rep6(16'h0000)};
    // 0x7FFF + 1.0 clamps to 0x7FFF, then -1.0 gives 0x7EFF; saturating
    // only at the end would give 0x7FFF.
    vt[6] = '{"step_sat", {16'h0100, 16'h0100}, {rep6(16'hFF00), rep6(16'h0100)},
              rep6(16'h7FFF), rep6(16'h7EFF), rep6(16'h7EFF)};

    // Reset state
    #12;
    chk("rst_y0", y0, 96'h0);
    chk("rst_y1", y1, 96'h0);
    chk("rst_valid", v0, 1'b0);
    chk("rst_busy", bz0, 1'b0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].z, vt[i].w, vt[i].b, lat, nb);
      chk({vt[i].name, "_lat"}, lat, 3);
      chk({vt[i].name, "_busy"}, nb, 3);
      chk({vt[i].name, "_y_id"}, y0, vt[i].e0);
      chk({vt[i].name, "_y_relu"}, y1, vt[i].e1);
      @(posedge clk); #1;
      chk({vt[i].name, "_pulse"}, v0, 1'b0);
      chk({vt[i].name, "_hold"}, y0, vt[i].e0);
    end

    // Start re-pulsed while busy, z changed after the start edge.
    @(negedge clk);
    z = vt[0].z; w = vt[0].w; b = vt[0].b; start = 1'b1;
    @(posedge clk); #1;                  // edge T
    z = {16'h0700, 16'h0300};
    @(posedge clk); #1;                  // T+1
    @(posedge clk); #1;                  // T+2
    start = 1'b0;
    cnt = 0; ycap = '0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (v0) begin
        cnt++;
        ycap = y0;
      end
    end
    chk("ignore_valid_cnt", cnt, 1);
    chk("latched_z_y", ycap, rep6(16'h0180));

    // start held high: one result every 4 cycles
    @(negedge clk);
    z = vt[0].z; w = vt[0].w; b = vt[0].b; start = 1'b1;
    cnt = 0; bad = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if (v0) begin
        cnt++;
        if ((n % 4) != 3) bad++;
      end
    end
    start = 1'b0;
    chk("stream_cnt", cnt, 4);
    chk("stream_spacing", bad, 0);
    repeat (4) @(posedge clk);

    // Reset between T+1 and T+2 (y holds 0x0180 beforehand)
    @(negedge clk);
    z = vt[4].z; w = vt[4].w; b = vt[4].b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_y0", y0, 96'h0);
    chk("midrst_y1", y1, 96'h0);
    chk("midrst_valid", v0, 1'b0);
    chk("midrst_busy", bz0, 1'b0);
    @(negedge clk); reset = 1'b0;
    run_op(vt[1].z, vt[1].w, vt[1].b, lat, nb);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_y", y0, vt[1].e0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
